// File: rtl/dsp_chain_3_operand_feeder_pkg.sv
// Shared definitions for the 3-stage fp16 cascade feeder: beat layout, widths
// and gather-state encoding.
package dsp_chain_3_operand_feeder_pkg;

  localparam int FP16_W = 16;
  localparam int FP32_W = 32;
  localparam int BEAT_W = 4 * FP16_W;

  localparam int TOP_A_MSB = 63;
  localparam int TOP_B_MSB = 47;
  localparam int BOT_A_MSB = 31;
  localparam int BOT_B_MSB = 15;

  localparam logic [1:0] G0 = 2'd0;
  localparam logic [1:0] G1 = 2'd1;
  localparam logic [1:0] G2 = 2'd2;

  typedef struct packed {
    logic [FP16_W-1:0] top_a;
    logic [FP16_W-1:0] top_b;
    logic [FP16_W-1:0] bot_a;
    logic [FP16_W-1:0] bot_b;
  } beat_t;

  function automatic beat_t to_beat(input logic [BEAT_W-1:0] d);
    beat_t b;
    b.top_a = d[TOP_A_MSB -: FP16_W];
    b.top_b = d[TOP_B_MSB -: FP16_W];
    b.bot_a = d[BOT_A_MSB -: FP16_W];
    b.bot_b = d[BOT_B_MSB -: FP16_W];
    return b;
  endfunction

endpackage

// File: rtl/dsp_chain_3_operand_feeder_if.sv
// Operand stream, skewed stage operands and result stream of the cascade feeder.
interface dsp_chain_3_operand_feeder_if;
  import dsp_chain_3_operand_feeder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BEAT_W-1:0] in_data;
  logic [BEAT_W-1:0] s1_ops;
  logic [BEAT_W-1:0] s2_ops;
  logic [BEAT_W-1:0] s3_ops;
  logic [FP32_W-1:0] chain_result;
  logic              out_valid;
  logic              out_ready;
  logic [FP32_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, chain_result, out_ready,
    input  in_ready, s1_ops, s2_ops, s3_ops, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, chain_result, out_ready,
    output in_ready, s1_ops, s2_ops, s3_ops, out_valid, out_data, busy
  );
endinterface

// File: rtl/dsp_chain_3_operand_feeder_result_fifo.sv
// Synchronous result FIFO with a registered head that holds its last value
// once the FIFO drains.
module feeder_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_head;
  logic             w_rd;
  logic             w_wr;
  logic [AW-1:0]    w_rd_ptr_nxt;

  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign count        = r_count;
  assign rd_data      = r_head;
  assign w_rd         = rd_en && !empty;
  assign w_wr         = wr_en && (!full || w_rd);
  assign w_rd_ptr_nxt = r_rd_ptr + AW'(1);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Head is refilled from memory on a pop, or straight from the write
      // port when the incoming entry becomes the new head.
      if (w_rd && (r_count > CW'(1)))
        r_head <= r_mem[w_rd_ptr_nxt];
      else if (w_wr && ((r_count == '0) || (w_rd && (r_count == CW'(1)))))
        r_head <= wr_data;
    end
  end

endmodule

// File: rtl/dsp_chain_3_operand_feeder.sv
// Gathers 3-beat jobs, launches stage operands skewed by the cascade latency
// and collects the final chain result into a credit-protected FIFO.
module dsp_chain_3_operand_feeder
  import dsp_chain_3_operand_feeder_pkg::*;
#(
  parameter int STAGE_LAT  = 2,
  parameter int RES_LAT    = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  dsp_chain_3_operand_feeder_if.slave   bus
);

  localparam int            CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  logic [1:0]        r_state;
  logic [CW-1:0]     r_credit;
  beat_t             r_hold0;
  beat_t             r_hold1;
  beat_t             r_s1_p0;
  beat_t             r_line1_p [STAGE_LAT];
  beat_t             r_line2_p [2*STAGE_LAT];
  beat_t             r_s2_p1;
  beat_t             r_s3_p2;
  logic [RES_LAT:0]  r_vld_p;

  logic              w_accept;
  logic              w_g0_accept;
  logic              w_launch;
  logic              w_pop;
  logic              w_capture;
  logic              w_empty;
  logic              w_full;
  logic [CW-1:0]     w_count;
  logic [FP32_W-1:0] w_head;

  // A job reserves its FIFO slot on its first beat, so a stalled consumer
  // blocks new jobs only at G0 and never mid-gather.
  assign bus.in_ready = !reset && ((r_state != G0) || (r_credit != '0));
  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_g0_accept  = w_accept && (r_state == G0);
  assign w_launch     = w_accept && (r_state == G2);
  assign w_pop        = bus.out_ready && !w_empty;
  assign w_capture    = r_vld_p[RES_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= G0;
      r_credit <= CREDIT_MAX;
    end else begin
      if (w_accept) begin
        case (r_state)
          G0:      r_state <= G1;
          G1:      r_state <= G2;
          default: r_state <= G0;
        endcase
      end
      if (w_g0_accept && !w_pop)
        r_credit <= r_credit - CW'(1);
      else if (w_pop && !w_g0_accept)
        r_credit <= r_credit + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && (r_state == G0)) r_hold0 <= to_beat(bus.in_data);
    if (w_accept && (r_state == G1)) r_hold1 <= to_beat(bus.in_data);
  end

  // p0: launch edge; stage-1 operands and skew-line entry, idle slots carry zero
  // p1/p2: skew-line outputs registered onto the stage-2/stage-3 ports
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_p0 <= '0;
      r_s2_p1 <= '0;
      r_s3_p2 <= '0;
      r_vld_p <= '0;
      for (int i = 0; i < STAGE_LAT; i++)     r_line1_p[i] <= '0;
      for (int i = 0; i < 2*STAGE_LAT; i++)   r_line2_p[i] <= '0;
    end else begin
      r_s1_p0      <= w_launch ? r_hold0 : '0;
      r_line1_p[0] <= w_launch ? r_hold1 : '0;
      r_line2_p[0] <= w_launch ? to_beat(bus.in_data) : '0;
      for (int i = 1; i < STAGE_LAT; i++)     r_line1_p[i] <= r_line1_p[i-1];
      for (int i = 1; i < 2*STAGE_LAT; i++)   r_line2_p[i] <= r_line2_p[i-1];
      r_s2_p1      <= r_line1_p[STAGE_LAT-1];
      r_s3_p2      <= r_line2_p[2*STAGE_LAT-1];
      r_vld_p      <= {r_vld_p[RES_LAT-1:0], w_launch};
    end
  end

  feeder_result_fifo #(
    .WIDTH (FP32_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_capture),
    .wr_data (bus.chain_result),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_count)
  );

  assign bus.s1_ops    = r_s1_p0;
  assign bus.s2_ops    = r_s2_p1;
  assign bus.s3_ops    = r_s3_p2;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head;
  assign bus.busy      = (r_state != G0) || (|r_vld_p) || (w_count != '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_capture && w_full && !w_pop));

endmodule

// File: tb/tb_dsp_chain_3_operand_feeder.sv
// Directed bench: a hand-computed single-job table, then stream sequences
// checked against a small credit/FIFO/skew reference model.
module tb_dsp_chain_3_operand_feeder;

  logic clk = 1'b0;
  logic reset;

  dsp_chain_3_operand_feeder_if bus_a ();
  dsp_chain_3_operand_feeder_if bus_b ();

  dsp_chain_3_operand_feeder #(.STAGE_LAT(2), .RES_LAT(7), .FIFO_DEPTH(4)) dut_a (
    .clk (clk), .reset (reset), .bus (bus_a)
  );

  dsp_chain_3_operand_feeder #(.STAGE_LAT(1), .RES_LAT(3), .FIFO_DEPTH(2)) dut_b (
    .clk (clk), .reset (reset), .bus (bus_b)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic        vld;
    logic [63:0] d;
    logic        ordy;
    logic        irdy;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic        ov;
    logic [31:0] od;
    logic        busy;
  } vec_t;

  localparam logic [63:0] B0 = 64'h3C00_4000_3C00_3C00;
  localparam logic [63:0] B1 = 64'h4000_4000_3C00_4000;
  localparam logic [63:0] B2 = 64'h3C00_3C00_4000_4000;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          use_b;
  int          SL, RL, DEP;
  int          m_step;
  int          m_g;
  int          m_credit;
  bit          m_acc;
  logic [63:0] m_hold0, m_hold1;
  logic [31:0] m_last;
  logic [31:0] m_q [$];
  int          m_cap [$];
  logic [63:0] e_s1 [int];
  logic [63:0] e_s2 [int];
  logic [63:0] e_s3 [int];

  vec_t tbl [14];

  function automatic vec_t mk(input logic vld, input logic [63:0] d, input logic ordy,
                              input logic irdy, input logic [63:0] s1, input logic [63:0] s2,
                              input logic [63:0] s3, input logic ov, input logic [31:0] od,
                              input logic busy);
    vec_t v;
    v.vld = vld; v.d = d; v.ordy = ordy; v.irdy = irdy;
    v.s1 = s1; v.s2 = s2; v.s3 = s3; v.ov = ov; v.od = od; v.busy = busy;
    return v;
  endfunction

  function automatic logic [63:0] beat(input int k);
    logic [15:0] kk;
    kk = 16'(k);
    return {16'h3C00 + kk, 16'h4000 + kk, 16'h3800 + kk, 16'h4400 + kk};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step=%0d: got %h expected %h", nm, m_step, act, exp);
    end
  endtask

  task automatic model_clear();
    m_g = 0;
    m_credit = DEP;
    m_last = '0;
    m_q.delete();
    m_cap.delete();
    e_s1.delete();
    e_s2.delete();
    e_s3.delete();
  endtask

  task automatic idle_inputs();
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0; bus_a.chain_result = '0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0; bus_b.chain_result = '0;
  endtask

  // Holds reset across two edges; all outputs must already be at reset value
  // in the cycle after the first one.
  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst a in_ready", bus_a.in_ready, 0);
    chk("rst a s1", bus_a.s1_ops, 0);
    chk("rst a s2", bus_a.s2_ops, 0);
    chk("rst a s3", bus_a.s3_ops, 0);
    chk("rst a out_valid", bus_a.out_valid, 0);
    chk("rst a out_data", bus_a.out_data, 0);
    chk("rst a busy", bus_a.busy, 0);
    chk("rst b in_ready", bus_b.in_ready, 0);
    chk("rst b out_valid", bus_b.out_valid, 0);
    chk("rst b busy", bus_b.busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_step(input logic vld, input logic [63:0] d, input logic ordy);
    logic [63:0] s1, s2, s3;
    logic [31:0] od;
    logic        irdy, ov, bsy;
    logic        exp_irdy, pop;
    int          L;
    if (use_b) begin
      bus_b.in_valid = vld; bus_b.in_data = d; bus_b.out_ready = ordy;
      bus_b.chain_result = 32'h5000_0000 + 32'(m_step);
    end else begin
      bus_a.in_valid = vld; bus_a.in_data = d; bus_a.out_ready = ordy;
      bus_a.chain_result = 32'h5000_0000 + 32'(m_step);
    end
    @(negedge clk);
    if (use_b) begin
      irdy = bus_b.in_ready; s1 = bus_b.s1_ops; s2 = bus_b.s2_ops; s3 = bus_b.s3_ops;
      ov = bus_b.out_valid; od = bus_b.out_data; bsy = bus_b.busy;
    end else begin
      irdy = bus_a.in_ready; s1 = bus_a.s1_ops; s2 = bus_a.s2_ops; s3 = bus_a.s3_ops;
      ov = bus_a.out_valid; od = bus_a.out_data; bsy = bus_a.busy;
    end
    exp_irdy = (m_g != 0) || (m_credit != 0);
    chk("in_ready", irdy, exp_irdy);
    chk("s1_ops", s1, e_s1.exists(m_step) ? e_s1[m_step] : 64'h0);
    chk("s2_ops", s2, e_s2.exists(m_step) ? e_s2[m_step] : 64'h0);
    chk("s3_ops", s3, e_s3.exists(m_step) ? e_s3[m_step] : 64'h0);
    chk("out_valid", ov, m_q.size() != 0);
    chk("out_data", od, (m_q.size() != 0) ? m_q[0] : m_last);
    chk("busy", bsy, (m_g != 0) || (m_cap.size() != 0) || (m_q.size() != 0));
    m_acc = vld && exp_irdy;
    pop   = ordy && (m_q.size() != 0);
    if (pop) begin
      m_last = m_q.pop_front();
      m_credit++;
    end
    if (m_cap.size() != 0 && m_cap[0] == m_step) begin
      void'(m_cap.pop_front());
      m_q.push_back(32'h5000_0000 + 32'(m_step));
    end
    if (m_acc) begin
      case (m_g)
        0: begin m_hold0 = d; m_credit--; end
        1: m_hold1 = d;
        default: begin
          L = m_step + 1;
          e_s1[L] = m_hold0;
          e_s2[L + SL] = m_hold1;
          e_s3[L + 2*SL] = d;
          m_cap.push_back(L + RL);
        end
      endcase
      m_g = (m_g + 1) % 3;
    end
    @(posedge clk); #1;
    m_step++;
  endtask

  // Offers nbeats consecutive beats, advancing only on accepted handshakes;
  // out_ready rises at step ordy_on and stays high.
  task automatic stream(input int nbeats, input int nsteps, input int ordy_on, input int base);
    int bi;
    bi = 0;
    for (int s = 0; s < nsteps; s++) begin
      do_step(bi < nbeats, beat(base + bi), s >= ordy_on);
      if (m_acc) bi++;
    end
  endtask

  initial begin
    reset = 1'b1;
    use_b = 1'b0;
    SL = 2; RL = 7; DEP = 4;
    m_step = 0;
    idle_inputs();
    do_reset();

    // single job, hand-computed: launch at step 3, capture of step-10 result
    for (int i = 0; i < 14; i++) tbl[i] = mk(0, 64'h0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 32'h0, 1);
    tbl[0]  = mk(1, B0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 32'h0, 0);
    tbl[1]  = mk(1, B1, 0, 1, 64'h0, 64'h0, 64'h0, 0, 32'h0, 1);
    tbl[2]  = mk(1, B2, 0, 1, 64'h0, 64'h0, 64'h0, 0, 32'h0, 1);
    tbl[3]  = mk(0, 64'h0, 0, 1, B0, 64'h0, 64'h0, 0, 32'h0, 1);
    tbl[5]  = mk(0, 64'h0, 0, 1, 64'h0, B1, 64'h0, 0, 32'h0, 1);
    tbl[7]  = mk(0, 64'h0, 0, 1, 64'h0, 64'h0, B2, 0, 32'h0, 1);
    tbl[11] = mk(0, 64'h0, 0, 1, 64'h0, 64'h0, 64'h0, 1, 32'h100A, 1);
    tbl[12] = mk(0, 64'h0, 1, 1, 64'h0, 64'h0, 64'h0, 1, 32'h100A, 1);
    tbl[13] = mk(0, 64'h0, 0, 1, 64'h0, 64'h0, 64'h0, 0, 32'h100A, 0);
    for (int i = 0; i < 14; i++) begin
      bus_a.in_valid     = tbl[i].vld;
      bus_a.in_data      = tbl[i].d;
      bus_a.out_ready    = tbl[i].ordy;
      bus_a.chain_result = 32'h1000 + 32'(i);
      @(negedge clk);
      chk("t1 in_ready", bus_a.in_ready, tbl[i].irdy);
      chk("t1 s1_ops", bus_a.s1_ops, tbl[i].s1);
      chk("t1 s2_ops", bus_a.s2_ops, tbl[i].s2);
      chk("t1 s3_ops", bus_a.s3_ops, tbl[i].s3);
      chk("t1 out_valid", bus_a.out_valid, tbl[i].ov);
      chk("t1 out_data", bus_a.out_data, tbl[i].od);
      chk("t1 busy", bus_a.busy, tbl[i].busy);
      @(posedge clk); #1;
    end

    // back-to-back: four jobs, consumer always ready
    do_reset();
    stream(12, 30, 0, 0);

    // backpressure: six jobs offered, consumer stalled until step 30, then
    // a pop with a rejected beat and a pop coinciding with a G0 accept
    do_reset();
    stream(18, 70, 30, 16);

    // reset in G1 with two results queued and one job in the skew pipeline
    stream(9, 13, 1000, 40);
    do_step(1'b1, beat(49), 1'b0);
    do_reset();
    stream(3, 16, 0, 60);

    // minimal-latency, two-deep configuration
    use_b = 1'b1;
    SL = 1; RL = 3; DEP = 2;
    do_reset();
    stream(12, 45, 12, 80);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
